// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, lock states and tracker bundle.
// Shared by the display driver and the capture path.
package vga_timing_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = 800;
  localparam int V_ACTIVE  = 480;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = 525;
  localparam int BLK_SHIFT = 3;
  localparam int MEM_COLS  = 80;
  localparam int ADDR_W    = 13;
  localparam int PIX_W     = 3;
  localparam int TMO_LINES = 2;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_e;

  // Per-strobe view of the tracker, using post-update counters
  // so x/y line up with the pixel sampled on the same strobe.
  typedef struct packed {
    logic       stb;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame;
    logic       loss;
  } trk_t;

  // Block address with the 80-block row pitch as shift-add.
  function automatic logic [ADDR_W-1:0] blk_addr(
    input logic [9:0] x,
    input logic [9:0] y
  );
    logic [ADDR_W-1:0] c;
    logic [ADDR_W-1:0] r;
    c = ADDR_W'(x >> BLK_SHIFT);
    r = ADDR_W'(y >> BLK_SHIFT);
    return c + (r << 6) + (r << 4);
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Sync tracker: HS/VS edge detect, h/v counters, timeout, lock FSM.
// Ports: clk, rst, pix_en, vga_hs, vga_vs in; trk bundle, locked out.
module vga_sync_tracker #(
  parameter int H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int H_TOTAL   = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP,
  parameter int V_TOTAL   = vga_timing_pkg::V_TOTAL,
  parameter int TMO_LINES = vga_timing_pkg::TMO_LINES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  input  logic                  vga_hs,
  input  logic                  vga_vs,
  output vga_timing_pkg::trk_t  trk,
  output logic                  locked
);
  import vga_timing_pkg::*;

  localparam int H_OFF = H_SYNC + H_BP;
  localparam int V_OFF = V_SYNC + V_BP;
  localparam int TMO   = TMO_LINES * H_TOTAL;
  localparam int TMO_W = $clog2(TMO + 1);

  state_e           state_q;
  state_e           state_d;
  logic             hs_q;
  logic             vs_q;
  logic             vs_pend_q;
  logic [9:0]       hcnt_q;
  logic [9:0]       vcnt_q;
  logic [9:0]       hcnt_d;
  logic [9:0]       vcnt_d;
  logic [TMO_W-1:0] tmo_q;
  logic             hs_fall;
  logic             vs_fall;
  logic             line_bad;
  logic             frame_bad;
  logic             tmo_hit;
  logic             loss;
  logic             frame;
  logic [9:0]       x;
  logic [9:0]       y;

  assign hs_fall   = pix_en & hs_q & ~vga_hs;
  assign vs_fall   = pix_en & vs_q & ~vga_vs;
  assign line_bad  = hs_fall
                   & (hcnt_q != 10'(H_TOTAL - 1));
  assign frame_bad = vs_fall
                   & (vcnt_q != 10'(V_TOTAL - 1));
  assign tmo_hit   = pix_en & ~hs_fall
                   & (state_q != SEARCH)
                   & (tmo_q == TMO_W'(TMO - 1));

  // Counters hold at full scale so a stalled stream never
  // wraps back into the active window.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (hs_fall) begin
        hcnt_d = '0;
      end else if (!(&hcnt_q)) begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
    if (hs_fall) begin
      if (vs_fall || vs_pend_q) begin
        vcnt_d = '0;
      end else if (!(&vcnt_q)) begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    loss    = 1'b0;
    frame   = 1'b0;
    if (pix_en) begin
      unique case (state_q)
        SEARCH: begin
          if (vs_fall) state_d = VERIFY;
        end
        VERIFY: begin
          if (line_bad || tmo_hit) begin
            state_d = SEARCH;
          end else if (vs_fall && !frame_bad) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (line_bad || frame_bad || tmo_hit) begin
            state_d = SEARCH;
            loss    = 1'b1;
          end else if (vs_fall) begin
            frame = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      vs_pend_q <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      tmo_q     <= '0;
      locked    <= 1'b0;
    end else if (pix_en) begin
      state_q   <= state_d;
      hs_q      <= vga_hs;
      vs_q      <= vga_vs;
      vs_pend_q <= hs_fall ? 1'b0 : (vs_pend_q | vs_fall);
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      locked    <= (state_d == LOCKED);
      if (hs_fall || tmo_hit || state_d == SEARCH) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end
  end

  assign x = hcnt_d - 10'(H_OFF);
  assign y = vcnt_d - 10'(V_OFF);

  always_comb begin
    trk.stb    = pix_en;
    trk.x      = x;
    trk.y      = y;
    trk.active = (x < 10'(H_ACTIVE)) & (y < 10'(V_ACTIVE));
    trk.frame  = frame;
    trk.loss   = loss;
  end

endmodule

// File: rtl/vga_capture.sv
// VGA frame grabber: locks to HS/VS, writes one sample per 8x8 block
// to an 80x60 RAM. Ports: clk, rst, pix_en, vga_hs, vga_vs, pixel,
// capture_en in; wr_en/wr_addr/wr_data, locked, frame_done, err_cnt out.
module vga_capture #(
  parameter int H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int H_TOTAL   = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP,
  parameter int V_TOTAL   = vga_timing_pkg::V_TOTAL,
  parameter int TMO_LINES = vga_timing_pkg::TMO_LINES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_en,
  input  logic                              vga_hs,
  input  logic                              vga_vs,
  input  logic [vga_timing_pkg::PIX_W-1:0]  pixel,
  input  logic                              capture_en,
  output logic                              wr_en,
  output logic [vga_timing_pkg::ADDR_W-1:0] wr_addr,
  output logic [vga_timing_pkg::PIX_W-1:0]  wr_data,
  output logic                              locked,
  output logic                              frame_done,
  output logic [7:0]                        err_cnt
);
  import vga_timing_pkg::*;

  trk_t trk;
  logic armed_q;
  logic hit;

  vga_sync_tracker #(
    .H_ACTIVE  (H_ACTIVE),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .H_TOTAL   (H_TOTAL),
    .V_ACTIVE  (V_ACTIVE),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .V_TOTAL   (V_TOTAL),
    .TMO_LINES (TMO_LINES)
  ) u_trk (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .vga_hs (vga_hs),
    .vga_vs (vga_vs),
    .trk    (trk),
    .locked (locked)
  );

  // Block origin in an armed frame; a strobe that also drops
  // lock abandons the frame, so its write is suppressed.
  assign hit = trk.stb & armed_q & trk.active & ~trk.loss
             & (trk.x[BLK_SHIFT-1:0] == '0)
             & (trk.y[BLK_SHIFT-1:0] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err_cnt    <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (trk.loss) begin
        armed_q <= 1'b0;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (trk.frame) begin
        frame_done <= armed_q;
        armed_q    <= capture_en;
      end
      if (hit) begin
        wr_en   <= 1'b1;
        wr_addr <= blk_addr(trk.x, trk.y);
        wr_data <= pixel;
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a shrunken raster, plus a
// tiny-raster instance that drives err_cnt into saturation.
module tb_vga_capture;

  localparam int HS = 4;
  localparam int HB = 4;
  localparam int HA = 64;
  localparam int HT = 80;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 16;
  localparam int VT = 23;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic        vga_hs;
  logic        vga_vs;
  logic [2:0]  pixel;
  logic        capture_en;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [2:0]  wr_data;
  logic        locked;
  logic        frame_done;
  logic [7:0]  err_cnt;

  logic        rst2;
  logic        pe2;
  logic        hs2;
  logic        vs2;
  logic [2:0]  pix2;
  logic        cap2;
  logic        wr_en2;
  logic [12:0] wr_addr2;
  logic [2:0]  wr_data2;
  logic        locked2;
  logic        fd2;
  logic [7:0]  err2;

  always #5 clk = ~clk;

  vga_capture #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .TMO_LINES(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .pixel(pixel),
    .capture_en(capture_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .locked(locked),
    .frame_done(frame_done), .err_cnt(err_cnt)
  );

  vga_capture #(
    .H_ACTIVE(1), .H_SYNC(1), .H_BP(1), .H_TOTAL(4),
    .V_ACTIVE(1), .V_SYNC(1), .V_BP(1), .V_TOTAL(4),
    .TMO_LINES(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .pix_en(pe2),
    .vga_hs(hs2), .vga_vs(vs2), .pixel(pix2),
    .capture_en(cap2), .wr_en(wr_en2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .locked(locked2),
    .frame_done(fd2), .err_cnt(err2)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  wr_seen = 0;
  int  fd_seen = 0;
  int  mem [0:255];

  task automatic check(input string name, input int act,
                       input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (frame_done) fd_seen++;
    if (wr_en2) begin
      total++;
      bad++;
      $display("FAIL tiny_wr: got write addr %0d want none",
               wr_addr2);
    end
    if (wr_en) begin
      wr_seen++;
      if (wr_addr < 256) mem[wr_addr] = int'(wr_data);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wr: got addr %0d data %0d want none",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(wr_addr), e.addr);
        check("wr_data", int'(wr_data), e.data);
      end
    end
  end

  task automatic strobe(input int h, input int v, input bit arm);
    int  x;
    int  y;
    bit  act;
    wr_t e;
    x = h - HS - HB;
    y = v - VS - VB;
    act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    pix_en = 1'b1;
    vga_hs = (h >= HS);
    vga_vs = (v >= VS);
    if (act)
      pixel = 3'(((x >> 3) + (x & 7) + 2 * (y & 7) + (y >> 3)) & 7);
    else
      pixel = 3'd5;
    if (arm && act && (x % 8 == 0) && (y % 8 == 0)) begin
      e.addr = (x >> 3) + (y >> 3) * 80;
      e.data = ((x >> 3) + (y >> 3)) & 7;
      exp_q.push_back(e);
    end
    @(negedge clk);
    pix_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic line(input int v, input int len, input bit arm);
    for (int h = 0; h < len; h++) strobe(h, v, arm);
  endtask

  task automatic frame(input bit arm);
    for (int v = 0; v < VT; v++) line(v, HT, arm);
  endtask

  task automatic tstrobe(input int h, input int v);
    hs2 = (h >= 1);
    vs2 = (v >= 1);
    @(negedge clk);
  endtask

  task automatic tframe(input bit short_line);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < ((short_line && v == 1) ? 3 : 4); h++)
        tstrobe(h, v);
  endtask

  task automatic tiny_seq();
    for (int n = 1; n <= 300; n++) begin
      tframe(1'b0);
      tframe(1'b0);
      if (n == 1) check("tiny_lock", int'(locked2), 1);
      tframe(1'b1);
      if (n == 1) begin
        check("tiny_unlock", int'(locked2), 0);
        check("tiny_err1", int'(err2), 1);
      end
      if (n == 100) check("tiny_err100", int'(err2), 100);
      if (n == 254) check("tiny_err254", int'(err2), 254);
      if (n == 255) check("tiny_err255", int'(err2), 255);
      if (n == 300) check("tiny_err_sat", int'(err2), 255);
    end
  endtask

  task automatic main_seq();
    capture_en = 1'b0;
    frame(1'b0);
    check("lock_after_f1", int'(locked), 0);
    frame(1'b0);
    check("lock_after_f2", int'(locked), 1);
    check("no_wr_nominal", wr_seen, 0);

    capture_en = 1'b1;
    frame(1'b1);
    capture_en = 1'b0;
    frame(1'b0);
    check("frame_done_cnt", fd_seen, 1);
    check("cap_wr_cnt", wr_seen, 16);
    check("cap_q_empty", exp_q.size(), 0);
    check("mem0", mem[0], 0);
    check("mem7", mem[7], 7);
    check("mem80", mem[80], 1);
    check("mem87", mem[87], 0);

    for (int v = 0; v <= 10; v++)
      line(v, (v == 10) ? HT - 1 : HT, 1'b0);
    check("lock_before_bad_hs", int'(locked), 1);
    line(11, HT, 1'b0);
    check("lock_at_bad_hs", int'(locked), 0);
    check("err_bad_line", int'(err_cnt), 1);
    for (int v = 12; v < VT; v++) line(v, HT, 1'b0);
    frame(1'b0);
    check("verify_frame", int'(locked), 0);
    frame(1'b0);
    check("relock", int'(locked), 1);
    check("err_after_relock", int'(err_cnt), 1);

    for (int v = 0; v <= 4; v++) line(v, HT, 1'b0);
    repeat (80) strobe(50, VT - 1, 1'b0);
    check("lock_before_tmo", int'(locked), 1);
    strobe(50, VT - 1, 1'b0);
    check("lock_at_tmo", int'(locked), 0);
    check("err_tmo", int'(err_cnt), 2);

    frame(1'b0);
    frame(1'b0);
    check("relock_tmo", int'(locked), 1);
    capture_en = 1'b1;
    for (int v = 0; v <= 12; v++) line(v, HT, 1'b1);
    for (int h = 0; h < 32; h++) strobe(h, 13, 1'b1);
    rst = 1'b1;
    pix_en = 1'b1;
    vga_hs = 1'b1;
    vga_vs = 1'b1;
    pixel = 3'd1;
    @(negedge clk);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    pix_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int h = 33; h < HT; h++) strobe(h, 13, 1'b0);
    for (int v = 14; v < VT; v++) line(v, HT, 1'b0);
    frame(1'b0);
    capture_en = 1'b0;
    check("post_rst_locked", int'(locked), 0);
    check("post_rst_wr_cnt", wr_seen, 27);
    check("post_rst_q_empty", exp_q.size(), 0);
    check("post_rst_fd_cnt", fd_seen, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = -1;
    rst = 1'b1;
    pix_en = 1'b0;
    vga_hs = 1'b1;
    vga_vs = 1'b1;
    pixel = 3'd0;
    capture_en = 1'b0;
    rst2 = 1'b1;
    pe2 = 1'b1;
    hs2 = 1'b1;
    vs2 = 1'b1;
    pix2 = 3'd0;
    cap2 = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_wr_addr", int'(wr_addr), 0);
    check("reset_wr_data", int'(wr_data), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;
    rst2 = 1'b0;
    fork
      main_seq();
      tiny_seq();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
